// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types: branch counter states, next-PC select and default bubble.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipeline_pkg;

    // 2-bit saturating branch counter; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Next-PC source, listed in decreasing priority.
    typedef enum logic [2:0] {
        NPC_RESET,
        NPC_REDIRECT,
        NPC_HOLD,
        NPC_PRED,
        NPC_SEQ
    } npc_sel_e;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    function automatic logic ctr_predicts_taken(input ctr_e c);
        return (c == WT) || (c == ST);
    endfunction

    // Saturating step towards the resolved direction.
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e n;
        n = c;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/if_stage_btb_if.sv
// Fetch-stage bundle: control from EX/ID, instruction memory port and IF/ID outputs.
// Latency: n/a (wiring only).
// Backpressure: stall holds the stage; redirect overrides stall.
interface if_stage_btb_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic            upd_taken;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc4;
    logic [XLEN-1:0] id_inst;
    logic            id_valid;
    logic            id_pred_taken;
    logic [XLEN-1:0] id_pred_target;

    // Fetch stage side.
    modport slave (
        input  stall, redirect_valid, redirect_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken,
        input  imem_data,
        output imem_addr, pc,
        output id_pc, id_pc4, id_inst, id_valid, id_pred_taken, id_pred_target
    );

    // Rest-of-pipeline / memory side.
    modport master (
        output stall, redirect_valid, redirect_pc,
        output upd_valid, upd_pc, upd_target, upd_taken,
        output imem_data,
        input  imem_addr, pc,
        input  id_pc, id_pc4, id_inst, id_valid, id_pred_taken, id_pred_target
    );
endinterface

// File: rtl/fetch_btb.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup, update written at the edge.
// Latency: lookup 0 cycles; an update becomes visible to lookup one edge later (no bypass).
// Backpressure: none; updates are accepted every cycle regardless of stall/redirect.
module fetch_btb
    import pipeline_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];
    ctr_e                   ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]  lk_idx, upd_idx;
    logic [TAGW-1:0] lk_tag, upd_tag;
    logic            lk_hit, upd_hit;
    logic            unused_lsbs;

    // Instructions are word aligned, so the two low PC bits never select anything.
    assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx  = lookup_pc[IDX+1:2];
    assign lk_tag  = lookup_pc[XLEN-1:IDX+2];
    assign upd_idx = upd_pc[IDX+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX+2];

    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign pred_taken  = lk_hit && ctr_predicts_taken(ctr_q[lk_idx]);
    assign pred_target = pred_taken ? target_q[lk_idx] : '0;

    // Valid bits and counters: cleared on reset, trained by resolved branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= WT;
            end
        end
    end

    // Tag/target only change on a taken resolution; on a hit the tag rewrite is a no-op.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/if_stage_btb.sv
// Instruction fetch stage: PC register, BTB-predicted next-PC mux and IF/ID register.
// Latency: instruction at pc appears in id_inst one edge later.
// Backpressure: stall holds PC and IF/ID; redirect flushes IF/ID and wins over stall.
module if_stage_btb
    import pipeline_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [XLEN-1:0] NOP_INST    = XLEN'(NOP_INST_DEFAULT)
) (
    input logic         clk,
    input logic         clrn,
    if_stage_btb_if.slave bus
);
    logic [XLEN-1:0] pc_q, pc_plus4, pc_next;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    npc_sel_e        npc_sel;

    logic [XLEN-1:0] id_pc_q, id_pc4_q, id_inst_q, id_pred_target_q;
    logic            id_valid_q, id_pred_taken_q;

    fetch_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (clrn),
        .lookup_pc   (pc_q),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (bus.upd_valid),
        .upd_pc      (bus.upd_pc),
        .upd_target  (bus.upd_target),
        .upd_taken   (bus.upd_taken)
    );

    assign pc_plus4 = pc_q + XLEN'(4);

    // Next-PC source by priority: reset, redirect, stall, prediction, sequential.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (clrn)                    npc_sel = NPC_RESET;
        else if (bus.redirect_valid) npc_sel = NPC_REDIRECT;
        else if (bus.stall)          npc_sel = NPC_HOLD;
        else if (pred_taken)         npc_sel = NPC_PRED;
    end

    // Next-PC data mux.
    always_comb begin
        pc_next = pc_plus4;
        case (npc_sel)
            NPC_RESET:    pc_next = RESET_PC;
            NPC_REDIRECT: pc_next = bus.redirect_pc;
            NPC_HOLD:     pc_next = pc_q;
            NPC_PRED:     pc_next = pred_target;
            default:      pc_next = pc_plus4;
        endcase
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (clrn) pc_q <= RESET_PC;
        else      pc_q <= pc_next;
    end

    // IF/ID register: flush on reset/redirect, hold on stall, otherwise capture the fetch.
    always_ff @(posedge clk) begin
        if (clrn || bus.redirect_valid) begin
            id_inst_q        <= NOP_INST;
            id_valid_q       <= 1'b0;
            id_pred_taken_q  <= 1'b0;
            id_pred_target_q <= '0;
            id_pc_q          <= '0;
            id_pc4_q         <= '0;
        end else if (!bus.stall) begin
            id_inst_q        <= bus.imem_data;
            id_valid_q       <= 1'b1;
            id_pred_taken_q  <= pred_taken;
            id_pred_target_q <= pred_target;
            id_pc_q          <= pc_q;
            id_pc4_q         <= pc_plus4;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.imem_addr      = pc_q;
    assign bus.id_pc          = id_pc_q;
    assign bus.id_pc4         = id_pc4_q;
    assign bus.id_inst        = id_inst_q;
    assign bus.id_valid       = id_valid_q;
    assign bus.id_pred_taken  = id_pred_taken_q;
    assign bus.id_pred_target = id_pred_target_q;

endmodule

// File: tb/tb_if_stage_btb.sv
// Bench for the fetch stage: directed scenarios then random traffic against a behavioural model.
// Latency: model advances one step per clock edge.
// Backpressure: stall/redirect driven directly by the bench.
module tb_if_stage_btb;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0;

    logic clk;
    logic clrn;
    int   total = 0;
    int   bad   = 0;

    if_stage_btb_if #(.XLEN(32)) bus ();

    if_stage_btb #(
        .XLEN        (32),
        .BTB_ENTRIES (16),
        .RESET_PC    (RESET_PC),
        .NOP_INST    (NOP)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    // Instruction ROM: word i holds i+1.
    assign bus.imem_data = (bus.imem_addr >> 2) + 32'd1;

    always #5 clk = ~clk;

    // Behavioural model state.
    bit [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst, m_id_tgt;
    bit        m_id_valid, m_id_pt;
    bit        m_valid [16];
    bit [31:0] m_tag   [16];
    bit [31:0] m_tgt   [16];
    int        m_ctr   [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        m_id_inst  = NOP;
        m_id_valid = 0;
        m_id_pt    = 0;
        m_id_tgt   = 0;
        m_id_pc    = 0;
        m_id_pc4   = 0;
    endtask

    // One clock edge: drive inputs, advance the model, then compare everything visible.
    task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rp,
                        input bit uv, input logic [31:0] up, input logic [31:0] ut, input bit utk);
        int        li, ui;
        bit        hit, pt;
        bit [31:0] ptg;
        @(negedge clk);
        clrn               = r;
        bus.stall          = s;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.upd_valid      = uv;
        bus.upd_pc         = up;
        bus.upd_target     = ut;
        bus.upd_taken      = utk;

        li  = int'((m_pc / 4) % 16);
        hit = m_valid[li] && (m_tag[li] == m_pc / 64);
        pt  = hit && (m_ctr[li] >= 2);
        ptg = pt ? m_tgt[li] : 32'h0;

        if (r) begin
            m_pc = RESET_PC;
            model_flush();
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
        end else begin
            if (uv) begin
                ui = int'((up / 4) % 16);
                if (m_valid[ui] && m_tag[ui] == up / 64) begin
                    if (utk) begin
                        m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                        m_tgt[ui] = ut;
                    end else begin
                        m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                    end
                end else if (utk) begin
                    m_valid[ui] = 1;
                    m_tag[ui]   = up / 64;
                    m_tgt[ui]   = ut;
                    m_ctr[ui]   = 2;
                end
            end
            if (rv) begin
                m_pc = rp;
                model_flush();
            end else if (!s) begin
                m_id_inst  = m_pc / 4 + 1;
                m_id_pc    = m_pc;
                m_id_pc4   = m_pc + 4;
                m_id_pt    = pt;
                m_id_tgt   = ptg;
                m_id_valid = 1;
                m_pc       = pt ? ptg : m_pc + 4;
            end
        end

        @(posedge clk);
        #1;
        check("pc",             bus.pc,                    m_pc);
        check("imem_addr",      bus.imem_addr,             m_pc);
        check("id_pc",          bus.id_pc,                 m_id_pc);
        check("id_pc4",         bus.id_pc4,                m_id_pc4);
        check("id_inst",        bus.id_inst,               m_id_inst);
        check("id_valid",       32'(bus.id_valid),         32'(m_id_valid));
        check("id_pred_taken",  32'(bus.id_pred_taken),    32'(m_id_pt));
        check("id_pred_target", bus.id_pred_target,        m_id_tgt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        clk  = 0;
        clrn = 1;
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
        bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_target = 0; bus.upd_taken = 0;

        // Reset and free run.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_pc", bus.pc, 32'h0);
        check("reset_id_valid", 32'(bus.id_valid), 32'h0);
        run(2);
        check("run_id_inst", bus.id_inst, 32'h2);

        // Two-cycle stall at pc=0x8.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("stall_pc", bus.pc, 32'h8);
        run(1);
        check("resume_pc", bus.pc, 32'hC);

        // Allocate 0x10 -> 0x40 and hit it.
        step(0, 0, 0, 0, 1, 32'h10, 32'h40, 1);
        check("pc_at_branch", bus.pc, 32'h10);
        run(1);
        check("pred_pc", bus.pc, 32'h40);
        check("pred_flag", 32'(bus.id_pred_taken), 32'h1);

        // Two not-taken trainings drop the counter to strongly not-taken.
        step(0, 0, 0, 0, 1, 32'h10, 32'h0, 0);
        step(0, 0, 0, 0, 1, 32'h10, 32'h0, 0);
        step(0, 0, 1, 32'h10, 0, 0, 0, 0);
        run(1);
        check("weak_fallthrough", bus.pc, 32'h14);

        // Redirect beats a simultaneous stall.
        step(0, 1, 1, 32'h80, 0, 0, 0, 0);
        check("redir_pc", bus.pc, 32'h80);
        check("redir_valid", 32'(bus.id_valid), 32'h0);
        run(1);
        check("redir_next", bus.pc, 32'h84);

        // Aliasing: 0x50 evicts 0x10 at the same index.
        step(0, 0, 0, 0, 1, 32'h10, 32'h40, 1);
        step(0, 0, 0, 0, 1, 32'h50, 32'h60, 1);
        step(0, 0, 1, 32'h10, 0, 0, 0, 0);
        run(1);
        check("alias_miss", bus.pc, 32'h14);
        step(0, 0, 1, 32'h50, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h50, 32'h70, 1);
        check("old_contents", bus.pc, 32'h60);
        step(0, 0, 1, 32'h50, 0, 0, 0, 0);
        run(1);
        check("new_contents", bus.pc, 32'h70);

        // Reset overrides stall, redirect and update.
        step(1, 1, 1, 32'h90, 1, 32'h20, 32'h44, 1);
        check("rst_override", bus.pc, RESET_PC);
        step(0, 0, 1, 32'h20, 0, 0, 0, 0);
        run(1);
        check("rst_no_write", bus.pc, 32'h24);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0,
                 32'($urandom_range(0, 63)) << 2,
                 $urandom_range(0, 2) == 0,
                 32'($urandom_range(0, 63)) << 2,
                 32'($urandom_range(0, 63)) << 2,
                 $urandom_range(0, 4) < 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
